adder_share_arbiter: RTL and testbench

- Shares one W-bit adder between NREQ requesters, for example the PC+4 path, the branch-target path and the address-generation path in the RISC-V datapath.
- Uses round-robin arbitration with a valid/ready handshake on each request port.
- Registers one result and returns it with the ID of the requester it belongs to.
- Sustains one addition per cycle with 1-cycle latency from accept to resp_valid.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/ripple_adder.sv | 27 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/adder_share_arbiter.sv | 103 ++++++++++
 tb/tb_adder_share_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: datapath constants shared by the RISC-V slice.
//   XLEN         default datapath width
//   REQ_*        fixed requester indices used when the shared adder is
//                wired into the datapath (port order on req_valid etc.)
package riscv_pkg;

  localparam int XLEN       = 32;

  localparam int REQ_PC4    = 0;
  localparam int REQ_BRANCH = 1;
  localparam int REQ_AGU    = 2;

endpackage

// File: rtl/ripple_adder.sv
// ripple_adder: (n+1)-bit ripple-carry adder.
//   a, b   operands [n:0]
//   cin    carry in
//   s      sum [n:0]
//   cout   carry out of bit n
module ripple_adder #(
  parameter int n = 31
) (
  input  logic [n:0] a,
  input  logic [n:0] b,
  input  logic       cin,
  output logic [n:0] s,
  output logic       cout
);

  logic [n+1:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i <= n; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[n+1];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req   request vector [NREQ-1:0]
//   ptr   highest-priority index for this cycle (must be < NREQ)
//   gnt   index of the first set req at or after ptr, wrapping
//   any   at least one request is set (gnt is meaningless otherwise)
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt,
  output logic            any
);

  localparam logic [IDW:0] NR = (IDW+1)'(NREQ);

  // Rotate the request vector so that ptr lands on bit 0; the first set
  // bit of the rotated vector is then the offset from ptr to the winner.
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off;
  logic [IDW:0]      wsum;
  logic [IDW:0]      wrap;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    off = '0;
    for (int j = NREQ-1; j >= 0; j--)
      if (rot[j]) off = IDW'(j);
  end

  assign any  = |req;
  assign wsum = {1'b0, ptr} + {1'b0, off};
  assign wrap = (wsum >= NR) ? wsum - NR : wsum;
  assign gnt  = wrap[IDW-1:0];

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one W-bit adder shared by NREQ requesters.
// Round-robin grant, valid/ready per requester, single result register
// returned with the owning requester's id. One add per cycle, result
// visible the cycle after accept.
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     per-requester handshake (ready is one-hot or 0)
//   req_a, req_b            packed operands, requester i at [i*W +: W]
//   resp_valid/resp_ready   result handshake
//   resp_id                 requester owning the result
//   resp_sum, resp_cout     (a+b) mod 2^W and its carry out
module adder_share_arbiter
  import riscv_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = XLEN,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_sum,
  output logic              resp_cout
);

  localparam logic [IDW-1:0] LAST = IDW'(NREQ-1);

  logic                      full;
  logic [IDW-1:0]            rr_ptr;
  logic [IDW-1:0]            gnt;
  logic                      any;
  logic                      can_accept;
  logic                      accept;
  logic [NREQ-1:0]           onehot;
  logic [NREQ-1:0][W-1:0]    a_arr;
  logic [NREQ-1:0][W-1:0]    b_arr;
  logic [W-1:0]              a_sel;
  logic [W-1:0]              b_sel;
  logic [W-1:0]              sum;
  logic                      cout;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .any (any)
  );

  // A drain in the same cycle frees the register, so accept is allowed
  // while full as long as the consumer takes the current result.
  assign can_accept = !full | resp_ready;
  assign accept     = rst_n & can_accept & any;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREQ; i++)
      onehot[i] = (gnt == IDW'(i));
  end

  // Ready depends only on valid/resp_ready/state, never on operands.
  assign req_ready = accept ? (onehot & req_valid) : '0;

  assign a_arr = req_a;
  assign b_arr = req_b;
  assign a_sel = a_arr[gnt];
  assign b_sel = b_arr[gnt];

  ripple_adder #(.n(W-1)) u_add (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      rr_ptr    <= '0;
      resp_id   <= '0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
    end else begin
      if (accept) begin
        full      <= 1'b1;
        resp_id   <= gnt;
        resp_sum  <= sum;
        resp_cout <= cout;
        rr_ptr    <= (gnt == LAST) ? '0 : gnt + 1'b1;
      end else if (resp_ready) begin
        full      <= 1'b0;
      end
    end
  end

  assign resp_valid = full;

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
  import riscv_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = XLEN;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_sum;
  logic              resp_cout;

  int errors = 0;
  int checks = 0;

  adder_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Tracks the architectural result: who is owed a result and what it is,
  // and whose turn it is next.
  logic            m_full;
  int              m_ptr;
  logic            m_id;
  logic [W:0]      m_res;
  logic [NREQ-1:0] m_rdy = '0;
  int              m_g;

  task automatic model_reset();
    m_full = 1'b0; m_ptr = 0; m_id = 1'b0; m_res = '0;
  endtask

  task automatic model_eval();
    m_rdy = '0;
    m_g   = -1;
    if (rst_n && (!m_full || resp_ready))
      for (int k = 0; k < NREQ; k++)
        if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
    if (m_g >= 0) m_rdy[m_g] = 1'b1;
  endtask

  task automatic model_clk();
    logic [W-1:0] a, b;
    if (m_g >= 0) begin
      a      = req_a[m_g*W +: W];
      b      = req_b[m_g*W +: W];
      m_res  = {1'b0, a} + {1'b0, b};
      m_id   = m_g[0];
      m_full = 1'b1;
      m_ptr  = (m_g + 1) % NREQ;
    end else if (resp_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    model_eval();
    chk({tag, "_ready"}, 64'(req_ready), 64'(m_rdy));
    chk({tag, "_valid"}, 64'(resp_valid), 64'(m_full));
    if (m_full) begin
      chk({tag, "_id"},  64'(resp_id), 64'(m_id));
      chk({tag, "_sum"}, 64'({resp_cout, resp_sum}), 64'(m_res));
    end
  endtask

  // Called in the low phase with inputs already applied.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic set_ops(input logic [W-1:0] a0, b0, a1, b1);
    req_a = {a1, a0};
    req_b = {b1, b0};
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  valid;
    logic        rdy;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  exp_ready;
    logic        exp_valid;
    logic        exp_id;
    logic [32:0] exp_res;
  } vec_t;

  vec_t vt [10];

  logic [NREQ-1:0] pend_acc;

  initial begin
    // expected results after each edge, starting from reset (ptr=0, empty)
    vt[0] = '{2'b01, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 2'b01, 1'b1, 1'b0, 33'd12};
    vt[1] = '{2'b11, 1'b1, 32'd1, 32'd2, 32'd10, 32'd20, 2'b10, 1'b1, 1'b1, 33'd30};
    vt[2] = '{2'b11, 1'b1, 32'd1, 32'd2, 32'd10, 32'd20, 2'b01, 1'b1, 1'b0, 33'd3};
    vt[3] = '{2'b11, 1'b1, 32'd1, 32'd2, 32'd10, 32'd20, 2'b10, 1'b1, 1'b1, 33'd30};
    vt[4] = '{2'b10, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 2'b10, 1'b1, 1'b1, 33'h1_0000_0000};
    vt[5] = '{2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 2'b01, 1'b1, 1'b0, 33'h1_0000_0000};
    vt[6] = '{2'b00, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 33'h1_0000_0000};
    vt[7] = '{2'b01, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 2'b01, 1'b1, 1'b0, 33'd7};
    vt[8] = '{2'b11, 1'b0, 32'd3, 32'd4, 32'd100, 32'd1, 2'b00, 1'b1, 1'b0, 33'd7};
    vt[9] = '{2'b11, 1'b1, 32'd3, 32'd4, 32'd100, 32'd1, 2'b10, 1'b1, 1'b1, 33'd101};

    // reset held with both requesters valid
    model_reset();
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    set_ops(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_sum",   64'({resp_cout, resp_sum}), 64'd0);
    chk("rst_id",    64'(resp_id), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_first_gnt", 64'(req_ready), 64'b01);
    req_valid = 2'b00;
    tick();

    // table
    for (int i = 0; i < 10; i++) begin
      req_valid  = vt[i].valid;
      resp_ready = vt[i].rdy;
      set_ops(vt[i].a0, vt[i].b0, vt[i].a1, vt[i].b1);
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(vt[i].exp_ready));
      tick();
      #1;
      chk($sformatf("tbl%0d_valid", i), 64'(resp_valid), 64'(vt[i].exp_valid));
      chk($sformatf("tbl%0d_id", i),    64'(resp_id), 64'(vt[i].exp_id));
      chk($sformatf("tbl%0d_sum", i),   64'({resp_cout, resp_sum}), 64'(vt[i].exp_res));
    end

    // backpressure: one accept, then 5 stalled cycles, then drain+accept
    req_valid  = 2'b01;
    resp_ready = 1'b1;
    set_ops(32'd9, 32'd9, 32'd50, 32'd50);
    #1;
    check_model("bp_acc");
    tick();
    resp_ready = 1'b0;
    req_valid  = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'd0);
      chk($sformatf("bp%0d_hold", c),  64'({resp_valid, resp_id, resp_cout, resp_sum}),
          64'({1'b1, 1'b0, 33'd18}));
      check_model($sformatf("bp%0d", c));
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'b10);
    tick();
    #1;
    chk("bp_release_valid", 64'(resp_valid), 64'd1);
    chk("bp_release_res",   64'({resp_id, resp_cout, resp_sum}), 64'({1'b1, 33'd100}));

    // reset while holding an unconsumed result
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    tick();
    #1;
    chk("mid_rst_pre_valid", 64'(resp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_no_stale", 64'(resp_valid), 64'd0);
    chk("mid_rst_ptr0",     64'(req_ready), 64'b01);
    tick();
    #1;
    check_model("mid_rst_after");

    // randomized traffic; requesters hold valid and operands until accepted
    pend_acc = '0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!req_valid[r] || pend_acc[r]) begin
          req_valid[r]      = ($urandom_range(0, 2) != 0);
          req_a[r*W +: W]   = rnd_op();
          req_b[r*W +: W]   = rnd_op();
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_model("rnd");
      tick();
      pend_acc = m_rdy;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
